// File: rtl/and_request_frontend_pkg.sv
// Shared BDD index constants and types for the AND request front end.
package and_request_frontend_pkg;

  localparam int INDEX_DEF = 30;
  localparam int STAGES    = 2;

  typedef logic [INDEX_DEF-1:0] index_t;

  localparam index_t BDD_ZERO = 30'h0;
  localparam index_t BDD_ONE  = 30'h1;

  // Complement edges live in bit 0, so a node and its negation differ only there.
  function automatic logic equal_negate(input index_t a, input index_t b);
    return (a ^ b) == BDD_ONE;
  endfunction

  typedef struct packed {
    logic   hit;
    index_t result;
  } eval_t;

endpackage

// File: rtl/and_request_frontend_if.sv
// Request / terminal-result / miss ports of the AND front end.
interface and_request_frontend_if #(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
);
  import and_request_frontend_pkg::*;

  logic             req_valid;
  logic             req_ready;
  index_t           req_f;
  index_t           req_g;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  index_t           res_value;
  logic [TAG_W-1:0] res_tag;

  logic             miss_valid;
  logic             miss_ready;
  index_t           miss_f;
  index_t           miss_g;
  logic [TAG_W-1:0] miss_tag;

  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output req_valid, req_f, req_g, req_tag, res_ready, miss_ready,
    input  req_ready, res_valid, res_value, res_tag,
           miss_valid, miss_f, miss_g, miss_tag, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_f, req_g, req_tag, res_ready, miss_ready,
    output req_ready, res_valid, res_value, res_tag,
           miss_valid, miss_f, miss_g, miss_tag, hit_count, miss_count
  );

endinterface

// File: rtl/and_request_frontend_terminal_eval.sv
// Terminal-case resolver for a canonically ordered AND operand pair (f <= g).
module and_terminal_eval
  import and_request_frontend_pkg::*;
(
  input  index_t f,
  input  index_t g,
  output eval_t  ev
);

  logic zero, rf, rg;

  always_comb begin
    zero = (f == BDD_ZERO) || (g == BDD_ZERO) || equal_negate(f, g);
    rf   = (f == g) || (g == BDD_ONE);
    rg   = (f == BDD_ONE);
    ev.hit = zero || rf || rg;
    if (zero)    ev.result = BDD_ZERO;
    else if (rf) ev.result = f;
    else if (rg) ev.result = g;
    else         ev.result = BDD_ZERO;
  end

endmodule

// File: rtl/and_request_frontend.sv
// Two-stage in-order AND front end: canonicalize, then resolve terminals or
// forward to the miss port, with saturating hit/miss counters.
module and_request_frontend
  import and_request_frontend_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  and_request_frontend_if.slave bus
);

  logic [STAGES:1]  vld_pipe;

  index_t           s1_f, s1_g;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_hit;
  index_t           res_value_q, miss_f_q, miss_g_q;
  logic [TAG_W-1:0] res_tag_q, miss_tag_q;

  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  logic  s2_free, s1_adv, accept, res_fire, miss_fire, drain;
  eval_t ev;

  and_terminal_eval u_eval (
    .f  (s1_f),
    .g  (s1_g),
    .ev (ev)
  );

  assign s2_free   = !vld_pipe[2] || (s2_hit ? bus.res_ready : bus.miss_ready);
  assign s1_adv    = vld_pipe[1] && s2_free;
  assign accept    = bus.req_valid && bus.req_ready;
  assign res_fire  = vld_pipe[2] && s2_hit && bus.res_ready;
  assign miss_fire = vld_pipe[2] && !s2_hit && bus.miss_ready;
  assign drain     = res_fire || miss_fire;

  // Ready looks through to the downstream readies so a full pipe still streams.
  assign bus.req_ready  = !reset && (!vld_pipe[1] || s2_free);

  assign bus.res_valid  = vld_pipe[2] && s2_hit;
  assign bus.res_value  = res_value_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.miss_valid = vld_pipe[2] && !s2_hit;
  assign bus.miss_f     = miss_f_q;
  assign bus.miss_g     = miss_g_q;
  assign bus.miss_tag   = miss_tag_q;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept || (vld_pipe[1] && !s1_adv);
      vld_pipe[2] <= s1_adv || (vld_pipe[2] && !drain);
    end
  end

  // S1: unsigned min/max ordering so the evaluator and miss path see f <= g.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_f   <= '0;
      s1_g   <= '0;
      s1_tag <= '0;
    end else if (accept) begin
      s1_f   <= (bus.req_f <= bus.req_g) ? bus.req_f : bus.req_g;
      s1_g   <= (bus.req_f <= bus.req_g) ? bus.req_g : bus.req_f;
      s1_tag <= bus.req_tag;
    end
  end

  // S2: each port keeps its own data registers so the idle port holds its last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_hit      <= 1'b0;
      res_value_q <= '0;
      res_tag_q   <= '0;
      miss_f_q    <= '0;
      miss_g_q    <= '0;
      miss_tag_q  <= '0;
    end else if (s1_adv) begin
      s2_hit <= ev.hit;
      if (ev.hit) begin
        res_value_q <= ev.result;
        res_tag_q   <= s1_tag;
      end else begin
        miss_f_q    <= s1_f;
        miss_g_q    <= s1_g;
        miss_tag_q  <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (res_fire && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_fire && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/and_request_frontend.md
Name: and_request_frontend

Overview:
Front end of the AND apply unit. It accepts (f, g, tag) AND requests over a valid/ready handshake and puts the operand pair in canonical order. It then resolves terminal cases and returns their results directly. Non-terminal pairs go to the miss port, which feeds the computed-table/expansion path. It is a two-stage in-order pipeline with per-path backpressure and hit/miss statistics.

Parameters:
TAG_W, 8, width of the request tag carried with each request
CNT_W, 16, width of the saturating hit/miss counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_f  in  INDEX_DEF (30)  operand f
req_g  in  INDEX_DEF (30)  operand g
req_tag  in  TAG_W  request tag
res_valid  out  1  terminal result available
res_ready  in  1  result consumer ready
res_value  out  INDEX_DEF  terminal result index
res_tag  out  TAG_W  tag of the resolved request
miss_valid  out  1  non-terminal request available
miss_ready  in  1  miss consumer ready
miss_f  out  INDEX_DEF  canonical f (numerically smaller operand)
miss_g  out  INDEX_DEF  canonical g
miss_tag  out  TAG_W  tag of the forwarded request
hit_count  out  CNT_W  terminal hits emitted
miss_count  out  CNT_W  misses emitted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Reset: all valid flags 0, counters 0, data registers 0. All outputs are 0 during reset, except req_ready, which is 0 while reset is asserted.
- Reset mid-operation discards in-flight requests without emitting them.
- Shared constants: BDD_ZERO = 30'h0, BDD_ONE = 30'h1. Negation flips bit 0, so EQUAL_NEGATE(a,b) = (a ^ b) == 30'h1.
- S1 (canonicalize): on accept, register f' = min(req_f, req_g) and g' = max(req_f, req_g) as unsigned values, plus the tag. Equal operands are unchanged.
- S2 (evaluate): from the S1 contents, compute zero = (f'==ZERO | g'==ZERO | EQUAL_NEGATE(f',g')), rf = (f'==g' | g'==ONE), rg = (f'==ONE).
  - Priority is zero > rf > rg.
  - Result is ZERO, f', or g' respectively.
  - hit = zero | rf | rg.
  - Register the hit flag, the result, f', g' and the tag into S2.
- Output routing: when S2 holds a hit, res_valid = 1 and miss_valid = 0. When S2 holds a miss, miss_valid = 1 and res_valid = 0. The other port's data fields hold their last values.
- S2 drains when the selected port's ready is 1.
- Advance rules:
  - s2_free = !s2_valid | (hit ? res_ready : miss_ready).
  - S1 moves to S2 when s1_valid & s2_free.
  - req_ready = !s1_valid | (s1_valid & s2_free), so full throughput is 1 request/cycle.
  - No combinational path exists from req_valid to any output valid. A combinational path from res_ready/miss_ready to req_ready is permitted.
- Latency: a request accepted at edge N is visible on an output at edge N+2 when there are no stalls.
- Ordering: strictly in order. A stalled miss blocks a following hit, and vice versa.
- Output stability: while a valid output is stalled, its data is held stable.
- Counters: increment on each completed handshake of their port and saturate at all-ones with no wrap.
- Simultaneous events: accept into S1, S1->S2 and drain of S2 in the same cycle are legal and lose nothing.

Decomposition:
- Shared constants header (existing): INDEX_DEF, BDD_ZERO, BDD_ONE, EQUAL_NEGATE. Tag and counter widths stay local parameters.
- One combinational sub-module, and_terminal_eval: inputs f and g; outputs hit and result with the priority above. It is instantiated in the S1->S2 path.
- Canonical ordering and the pipeline control live in the top module.

Test Plan:
- Reset then single request f=5, g=0 with res_ready=1 -> res_valid at cycle 2, res_value=0, hit_count=1.
- f=9, g=1 -> res_value=9. f=1, g=7 -> res_value=7. f=6, g=7 (negation pair) -> res_value=0. f=g=12 -> res_value=12.
- f=40, g=20, tag=3 -> miss_valid, miss_f=20, miss_g=40, miss_tag=3, miss_count=1, res_valid stays 0.
- Back-to-back stream of 8 alternating hit/miss requests with both readies high -> 8 outputs in request order, one per cycle, req_ready constant 1.
- miss_ready=0 with a miss in S2 and a hit queued behind it -> the hit is not emitted, req_ready drops once S1 is full, and the miss data stays stable. Release miss_ready -> the miss and then the hit are emitted in order.
- Assert reset while both stages are valid -> all valid flags drop immediately and counters clear; nothing is emitted after reset deasserts. Separately, force 65535 hits -> hit_count holds 16'hFFFF on the next hit.
